// File: rtl/vproc_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vproc_mem_arbiter_if
// Memory-side request/response bus between the arbiter and system memory.
//   req/addr/we/wdata : request, driven by the master (arbiter)
//   gnt               : memory accepts the request presented this cycle
//   rvalid/rdata/err  : one response per granted request, in order
// Modports:
//   master : arbiter side (drives the request, receives grant/response)
//   slave  : memory side  (receives the request, drives grant/response)
// Handshake: a request transfers in every cycle where req and gnt are both
// high; req/addr/we/wdata may change freely while gnt is low. rvalid is a
// single-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
interface vproc_mem_arbiter_if #(
   parameter int unsigned ADDR_BIT_W = 16,
   parameter int unsigned MEM_BYTE_W = 4
);
   logic                    req;
   logic [ADDR_BIT_W-1:0]   addr;
   logic                    we;
   logic [MEM_BYTE_W*8-1:0] wdata;
   logic                    gnt;
   logic                    rvalid;
   logic [MEM_BYTE_W*8-1:0] rdata;
   logic                    err;

   modport master (
      output req, addr, we, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/vproc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vproc_mem_arbiter
// Shares one memory request interface between two cache ports
// (port 0 = I-cache, port 1 = D-cache). Requests are arbitrated round-robin
// with a purely combinational request path; an in-order FIFO of 1-bit source
// IDs routes every memory response back to the port that issued it.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   reqN_req_i/addr_i/we_i/wdata_i  port N request (N = 0, 1)
//   reqN_gnt_o                 port N request accepted this cycle
//   reqN_rvalid_o              response for port N this cycle
//   req_rdata_o, req_err_o     response data/error, broadcast to both ports
//   mem_if (master)            memory request/response bus
//   dbg_cnt_o, dbg_rr_o        outstanding count and priority port (debug)
//
// Optional feature: define VPROC_MEM_ARB_LOCK_EN to keep granting the same
// port for as long as it keeps its request high after a grant, so line
// fill/spill bursts stay contiguous.
//
// Handshake: a port request transfers when reqN_req_i and reqN_gnt_o are
// both high; the arbiter stores no request data, so port inputs may change
// while ungranted. Responses (reqN_rvalid_o) are single-cycle pulses.
// ---------------------------------------------------------------------------
module vproc_mem_arbiter #(
   parameter int unsigned ADDR_BIT_W      = 16,
   parameter int unsigned MEM_BYTE_W      = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,

   input  logic                             req0_req_i,
   input  logic [ADDR_BIT_W-1:0]            req0_addr_i,
   input  logic                             req0_we_i,
   input  logic [MEM_BYTE_W*8-1:0]          req0_wdata_i,
   output logic                             req0_gnt_o,
   output logic                             req0_rvalid_o,

   input  logic                             req1_req_i,
   input  logic [ADDR_BIT_W-1:0]            req1_addr_i,
   input  logic                             req1_we_i,
   input  logic [MEM_BYTE_W*8-1:0]          req1_wdata_i,
   output logic                             req1_gnt_o,
   output logic                             req1_rvalid_o,

   output logic [MEM_BYTE_W*8-1:0]          req_rdata_o,
   output logic                             req_err_o,

   vproc_mem_arbiter_if.master              mem_if,

   output logic [$clog2(MAX_OUTSTANDING):0] dbg_cnt_o,
   output logic                             dbg_rr_o
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic                       rr_q, rr_d;
   logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic full, any_req, sel, grant, pop, head;

   assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign any_req = req0_req_i | req1_req_i;

`ifdef VPROC_MEM_ARB_LOCK_EN
   logic lock_q, lock_d, lock_id_q, lock_id_d, lock_hold;
   // Lock only holds while the locked port keeps requesting.
   assign lock_hold = lock_q & (lock_id_q ? req1_req_i : req0_req_i);
`endif

   always_comb begin
      // Only port 1 requesting -> 1; both -> priority port; otherwise 0.
      sel = req1_req_i & (~req0_req_i | rr_q);
`ifdef VPROC_MEM_ARB_LOCK_EN
      if (lock_hold) sel = lock_id_q;
`endif
   end

   assign grant = mem_if.req & mem_if.gnt;
   // A response with nothing outstanding is stale (e.g. issued before a
   // reset) and is dropped without touching any state.
   assign pop   = mem_if.rvalid & (cnt_q != '0);
   assign head  = fifo_q[rd_ptr_q];

   // Request path: gated to zero when no port requests.
   assign mem_if.req   = any_req & ~full;
   assign mem_if.addr  = ~any_req ? '0 : (sel ? req1_addr_i  : req0_addr_i);
   assign mem_if.we    = any_req & (sel ? req1_we_i : req0_we_i);
   assign mem_if.wdata = ~any_req ? '0 : (sel ? req1_wdata_i : req0_wdata_i);

   assign req0_gnt_o    = grant & ~sel;
   assign req1_gnt_o    = grant &  sel;
   assign req0_rvalid_o = pop & ~head;
   assign req1_rvalid_o = pop &  head;
   assign req_rdata_o   = mem_if.rdata;
   assign req_err_o     = mem_if.err;

   assign dbg_cnt_o = cnt_q;
   assign dbg_rr_o  = rr_q;

   always_comb begin
      rr_d     = rr_q;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (grant) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         rr_d             = ~sel;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({grant, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

`ifdef VPROC_MEM_ARB_LOCK_EN
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      // A new grant takes precedence over releasing the old lock, so the
      // other port's grant in the release cycle starts its own lock.
      if (grant) begin
         lock_d    = 1'b1;
         lock_id_d = sel;
      end else if (lock_q & ~lock_hold) begin
         lock_d    = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q      <= 1'b0;
         fifo_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
`ifdef VPROC_MEM_ARB_LOCK_EN
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
`endif
      end else begin
         rr_q      <= rr_d;
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
`ifdef VPROC_MEM_ARB_LOCK_EN
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
`endif
      end
   end

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vproc_mem_arbiter
// Directed bench for vproc_mem_arbiter. Expected grants ({port, addr}) and
// expected responses ({port, err, rdata}) are queued as stimulus is applied;
// a negedge monitor pops and compares whenever the DUT shows a grant or a
// response. Cycle-specific conditions (full, reset) are checked inline.
// ---------------------------------------------------------------------------
module tb_vproc_mem_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_req = 1'b0, req1_req = 1'b0;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0;
   logic          req0_we = 1'b0, req1_we = 1'b0;
   logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
   logic          req0_gnt, req1_gnt, req0_rvalid, req1_rvalid;
   logic [DW-1:0] req_rdata;
   logic          req_err;
   logic [2:0]    dbg_cnt;
   logic          dbg_rr;

   vproc_mem_arbiter_if #(.ADDR_BIT_W(AW), .MEM_BYTE_W(4)) mem_if ();

   vproc_mem_arbiter #(
      .ADDR_BIT_W(AW), .MEM_BYTE_W(4), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_req_i(req0_req), .req0_addr_i(req0_addr), .req0_we_i(req0_we),
      .req0_wdata_i(req0_wdata), .req0_gnt_o(req0_gnt), .req0_rvalid_o(req0_rvalid),
      .req1_req_i(req1_req), .req1_addr_i(req1_addr), .req1_we_i(req1_we),
      .req1_wdata_i(req1_wdata), .req1_gnt_o(req1_gnt), .req1_rvalid_o(req1_rvalid),
      .req_rdata_o(req_rdata), .req_err_o(req_err),
      .mem_if(mem_if.master),
      .dbg_cnt_o(dbg_cnt), .dbg_rr_o(dbg_rr)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [16:0] gnt_q[$];
   logic [33:0] rsp_q[$];

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (req0_gnt && req1_gnt) begin
            check("both_gnt", 64'(2'b11), 64'(2'b01));
         end else if (req0_gnt || req1_gnt) begin
            if (gnt_q.size() == 0) check("unexpected_gnt", 64'({req1_gnt, mem_if.addr}), 64'h1_0000_0000);
            else check("gnt", 64'({req1_gnt, mem_if.addr}), 64'(gnt_q.pop_front()));
         end
         if (req0_rvalid && req1_rvalid) begin
            check("both_rvalid", 64'(2'b11), 64'(2'b01));
         end else if (req0_rvalid || req1_rvalid) begin
            if (rsp_q.size() == 0) check("unexpected_rvalid", 64'({req1_rvalid, req_err, req_rdata}), 64'h1_0000_0000_0);
            else check("rsp", 64'({req1_rvalid, req_err, req_rdata}), 64'(rsp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_req = 1'b0; req1_req = 1'b0;
      mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0;
      mem_if.rdata = '0; mem_if.err = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic respond(input logic port, input logic err, input logic [DW-1:0] data);
      mem_if.rvalid = 1'b1; mem_if.err = err; mem_if.rdata = data;
      rsp_q.push_back({port, err, data});
   endtask

   // ---------------- stimulus ----------------
`ifdef VPROC_MEM_ARB_LOCK_EN
   logic [4:0] burst_ports = 5'b10000;  // index i = port of grant i
`else
   logic [4:0] burst_ports = 5'b11010;
`endif

   initial begin
      idle_inputs();
      req0_addr = 16'h1000; req0_we = 1'b0; req0_wdata = 32'h0000_00A0;
      req1_addr = 16'h4000; req1_we = 1'b1; req1_wdata = 32'h0000_00B1;
      do_reset();

      // Reset state: idle outputs zero, response bus passes through.
      mem_if.rdata = 32'hCAFE_0001; mem_if.err = 1'b1;
      @(negedge clk);
      check("rst_mem_req", 64'(mem_if.req), 64'd0);
      check("rst_mem_addr", 64'(mem_if.addr), 64'd0);
      check("rst_mem_we_wdata", 64'({mem_if.we, mem_if.wdata}), 64'd0);
      check("rst_gnts", 64'({req0_gnt, req1_gnt}), 64'd0);
      check("rst_rvalids", 64'({req0_rvalid, req1_rvalid}), 64'd0);
      check("rst_cnt_rr", 64'({dbg_cnt, dbg_rr}), 64'd0);
      check("rdata_pass", 64'({req_err, req_rdata}), 64'h1_CAFE_0001);
      tick();
      idle_inputs();

      // T1: single read from port 0, response the next cycle.
      req0_req = 1'b1; mem_if.gnt = 1'b1;
      gnt_q.push_back({1'b0, 16'h1000});
      @(negedge clk);
      check("t1_mem_addr", 64'(mem_if.addr), 64'h1000);
      check("t1_mem_we", 64'(mem_if.we), 64'd0);
      tick();
      req0_req = 1'b0;
      respond(1'b0, 1'b0, 32'hDEAD_BEEF);
      tick();
      idle_inputs();
      tick();

      // T2: both ports continuously -> 0,1,0,1, then answer all four.
      do_reset();
      req0_req = 1'b1; req1_req = 1'b1; mem_if.gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         gnt_q.push_back((i % 2 == 0) ? {1'b0, 16'h1000} : {1'b1, 16'h4000});
         tick();
      end
      req0_req = 1'b0; req1_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         respond(1'(i % 2), 1'b0, 32'h2000_0000 + 32'(i));
         tick();
      end
      idle_inputs();
      @(negedge clk);
      check("t2_cnt_drained", 64'(dbg_cnt), 64'd0);
      tick();

      // T3: port 1 alone, no responses -> 4 grants, then stall until a pop.
      do_reset();
      req1_req = 1'b1; mem_if.gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         gnt_q.push_back({1'b1, 16'h4000});
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t3_full_no_req", 64'({mem_if.req, req1_gnt}), 64'd0);
         check("t3_full_cnt", 64'(dbg_cnt), 64'd4);
         tick();
      end
      respond(1'b1, 1'b0, 32'h1111_0000);
      @(negedge clk);
      check("t3_full_pop_no_req", 64'(mem_if.req), 64'd0);
      tick();
      mem_if.rvalid = 1'b0;
      gnt_q.push_back({1'b1, 16'h4000});
      @(negedge clk);
      check("t3_fifth_req", 64'(mem_if.req), 64'd1);
      tick();
      req1_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         respond(1'b1, 1'b0, 32'h1111_0001 + 32'(i));
         tick();
      end
      idle_inputs();
      tick();

      // T4: grants 0,1,1 then responses with err 0,1,0.
      do_reset();
      mem_if.gnt = 1'b1;
      req0_req = 1'b1; gnt_q.push_back({1'b0, 16'h1000}); tick();
      req0_req = 1'b0; req1_req = 1'b1;
      req1_addr = 16'h4004; gnt_q.push_back({1'b1, 16'h4004}); tick();
      req1_addr = 16'h4008; gnt_q.push_back({1'b1, 16'h4008}); tick();
      req1_req = 1'b0;
      respond(1'b0, 1'b0, 32'h4400_0000); tick();
      respond(1'b1, 1'b1, 32'h4400_0001); tick();
      respond(1'b1, 1'b0, 32'h4400_0002); tick();
      idle_inputs();
      req1_addr = 16'h4000;
      tick();

      // T5: port 0 holds its request 4 cycles while port 1 also requests;
      // one response per cycle keeps the FIFO from filling.
      do_reset();
      mem_if.gnt = 1'b1;
      req0_addr = 16'h2000; req1_addr = 16'h3000;
      for (int i = 0; i < 6; i++) begin
         req0_req = (i < 4);
         req1_req = (i < 5);
         if (i < 5) gnt_q.push_back(burst_ports[i] ? {1'b1, 16'h3000} : {1'b0, 16'h2000});
         if (i >= 1) respond(burst_ports[i-1], 1'b0, 32'h5500_0000 + 32'(i));
         else mem_if.rvalid = 1'b0;
         tick();
      end
      idle_inputs();
      tick();

      // T6: reset with two outstanding, then two stale responses dropped.
      do_reset();
      mem_if.gnt = 1'b1;
      req0_req = 1'b1; gnt_q.push_back({1'b0, 16'h2000}); tick();
      req0_req = 1'b0; req1_req = 1'b1; gnt_q.push_back({1'b1, 16'h3000}); tick();
      idle_inputs();
      @(negedge clk);
      check("t6_cnt_before_rst", 64'(dbg_cnt), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_if.rvalid = 1'b1; mem_if.rdata = 32'h6600_0000 + 32'(i);
         @(negedge clk);
         check("t6_stray_rvalid", 64'({req0_rvalid, req1_rvalid}), 64'd0);
         tick();
         @(negedge clk);
         check("t6_cnt_after", 64'(dbg_cnt), 64'd0);
      end
      idle_inputs();
      tick();

      check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
      check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
